// File: rtl/pc_stack_unit_pkg.sv
// Shared CPU control constants: default datapath width, PC operation codes
// and the request priority encoder used by the PC unit and decoder checks.
package pc_stack_unit_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_NXT    = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_LOAD   = 3'd5
    } op_e;

    // Highest-priority request wins: load > ret > call > branch > nxt.
    function automatic op_e op_encode(input logic nxt, input logic branch,
                                      input logic call, input logic ret,
                                      input logic load);
        op_e op;
        if (load) begin
            op = OP_LOAD;
        end else if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (branch) begin
            op = OP_BRANCH;
        end else if (nxt) begin
            op = OP_NXT;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Decoder-to-PC-unit bundle: operation requests in, PC and stack status out.
interface pc_stack_unit_if #(
    parameter int WIDTH = pc_stack_unit_pkg::WIDTH_DEF,
    parameter int OFF_W = 8,
    parameter int DEPTH = 4
) ();
    localparam int DW = $clog2(DEPTH + 1);

    logic             nxt;
    logic             load;
    logic             branch;
    logic             call;
    logic             ret;
    logic             err_clr;
    logic [WIDTH-1:0] target;
    logic [OFF_W-1:0] offset;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] top;
    logic [DW-1:0]    depth;
    logic             stack_full;
    logic             stack_empty;
    logic             err;

    modport master (
        output nxt, load, branch, call, ret, err_clr, target, offset,
        input  pc, top, depth, stack_full, stack_empty, err
    );

    modport slave (
        input  nxt, load, branch, call, ret, err_clr, target, offset,
        output pc, top, depth, stack_full, stack_empty, err
    );
endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// Parametrised return-address LIFO; push and pop are ignored when they would
// overflow or underflow, so the caller decides how to report the fault.
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DW-1:0]    depth_r;
    logic [WIDTH-1:0] top_s;

    assign full  = (depth_r == DW'(DEPTH));
    assign empty = (depth_r == {DW{1'b0}});
    assign depth = depth_r;
    assign top   = top_s;

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_r <= {DW{1'b0}};
        end else if (push && !full) begin
            depth_r <= depth_r + DW'(1);
        end else if (pop && !empty) begin
            depth_r <= depth_r - DW'(1);
        end else begin
            depth_r <= depth_r;
        end
    end

    // Entry storage; the loop compare avoids indexing with the wider count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && !full && (depth_r == DW'(i))) begin
                    mem_r[i] <= din;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Top-of-stack select, zero when empty.
    always_comb begin
        top_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_r == DW'(i + 1)) begin
                top_s = mem_r[i];
            end else begin
                top_s = top_s;
            end
        end
    end
endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with step, relative branch, call/return via a
// hardware return stack, and a sticky fault flag for stack over/underflow.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int STEP      = 1,
    parameter int OFF_W     = 8,
    parameter int DEPTH     = 4,
    parameter int RESET_VEC = 0
) (
    input  logic            clk,
    input  logic            rst,
    pc_stack_unit_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_r;
    logic             err_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic             err_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             fault_s;
    logic [WIDTH-1:0] off_ext_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [WIDTH-1:0] top_s;
    logic [DW-1:0]    depth_s;
    logic             full_s;
    logic             empty_s;
    op_e              op_s;

    assign op_s       = op_encode(bus.nxt, bus.branch, bus.call, bus.ret, bus.load);
    assign off_ext_s  = WIDTH'($signed(bus.offset));
    assign ret_addr_s = pc_r + STEP_W;

    ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_addr_s),
        .top   (top_s),
        .depth (depth_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-PC, stack control and fault detection for the selected operation.
    always_comb begin
        pc_nxt_s = pc_r;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        fault_s  = 1'b0;
        case (op_s)
            OP_LOAD:   pc_nxt_s = bus.target;
            OP_RET: begin
                if (!empty_s) begin
                    pc_nxt_s = top_s;
                    pop_s    = 1'b1;
                end else begin
                    fault_s  = 1'b1;
                end
            end
            OP_CALL: begin
                if (!full_s) begin
                    pc_nxt_s = bus.target;
                    push_s   = 1'b1;
                end else begin
                    fault_s  = 1'b1;
                end
            end
            OP_BRANCH: pc_nxt_s = pc_r + off_ext_s;
            OP_NXT:    pc_nxt_s = ret_addr_s;
            default:   pc_nxt_s = pc_r;
        endcase
    end

    // A fault in the same cycle as err_clr keeps the flag set.
    always_comb begin
        if (fault_s) begin
            err_nxt_s = 1'b1;
        end else if (bus.err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // PC and fault flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r  <= WIDTH'(RESET_VEC);
            err_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.err         = err_r;
    assign bus.top         = top_s;
    assign bus.depth       = depth_s;
    assign bus.stack_full  = full_s;
    assign bus.stack_empty = empty_s;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench: directed test-plan sequences plus random requests,
// compared every cycle against a queue-based reference model.
module tb_pc_stack_unit;
    localparam int WIDTH = 16;
    localparam int OFF_W = 8;
    localparam int DEPTH = 4;
    localparam int STEP  = 1;

    logic clk;
    logic rst;

    pc_stack_unit_if #(.WIDTH(WIDTH), .OFF_W(OFF_W), .DEPTH(DEPTH)) bus ();

    pc_stack_unit #(.WIDTH(WIDTH), .STEP(STEP), .OFF_W(OFF_W),
                    .DEPTH(DEPTH), .RESET_VEC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model state.
    logic [31:0] m_pc;
    bit          m_err;
    int          m_stk[$];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'd0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_top;
        exp_top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 32'd0;
        check_val({tag, ".pc"},    32'(bus.pc),          m_pc);
        check_val({tag, ".depth"}, 32'(bus.depth),       32'(m_stk.size()));
        check_val({tag, ".top"},   32'(bus.top),         exp_top);
        check_val({tag, ".full"},  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
        check_val({tag, ".empty"}, 32'(bus.stack_empty), 32'(m_stk.size() == 0));
        check_val({tag, ".err"},   32'(bus.err),         32'(m_err));
    endtask

    // Applies the architectural rules for one clock edge to the model.
    task automatic model_step(input bit n, input bit ld, input bit br,
                              input bit cl, input bit rt, input bit clr,
                              input logic [15:0] tgt, input logic [7:0] off);
        bit fault;
        int soff;
        fault = 1'b0;
        soff  = int'($signed(off));
        if (ld) begin
            m_pc = 32'(tgt);
        end else if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else fault = 1'b1;
        end else if (cl) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(int'((m_pc + 32'(STEP)) % 32'd65536));
                m_pc = 32'(tgt);
            end else begin
                fault = 1'b1;
            end
        end else if (br) begin
            m_pc = 32'(int'(m_pc) + soff) & 32'h0000_FFFF;
        end else if (n) begin
            m_pc = (m_pc + 32'(STEP)) % 32'd65536;
        end
        if (fault) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic do_op(input string tag, input bit n, input bit ld,
                         input bit br, input bit cl, input bit rt,
                         input bit clr, input logic [15:0] tgt,
                         input logic [7:0] off);
        @(negedge clk);
        bus.nxt = n; bus.load = ld; bus.branch = br; bus.call = cl;
        bus.ret = rt; bus.err_clr = clr; bus.target = tgt; bus.offset = off;
        @(posedge clk);
        model_step(n, ld, br, cl, rt, clr, tgt, off);
        #1;
        check_all(tag);
        bus.nxt = 1'b0; bus.load = 1'b0; bus.branch = 1'b0; bus.call = 1'b0;
        bus.ret = 1'b0; bus.err_clr = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.nxt = 1'b0; bus.load = 1'b0; bus.branch = 1'b0; bus.call = 1'b0;
        bus.ret = 1'b0; bus.err_clr = 1'b0; bus.target = 16'd0; bus.offset = 8'd0;
        rst = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) do_op("idle", 0, 0, 0, 0, 0, 0, 16'd0, 8'd0);

        for (int i = 0; i < 3; i++) do_op("nxt", 1, 0, 0, 0, 0, 0, 16'd0, 8'd0);
        check_val("nxt3", 32'(bus.pc), 32'd3);
        do_op("load", 0, 1, 0, 0, 0, 0, 16'd25, 8'd0);
        check_val("load25", 32'(bus.pc), 32'd25);
        do_op("ldprio", 1, 1, 0, 0, 0, 0, 16'd20, 8'd0);
        check_val("ldprio", 32'(bus.pc), 32'd20);
        do_op("load", 0, 1, 0, 0, 0, 0, 16'd25, 8'd0);
        do_op("branch", 0, 0, 1, 0, 0, 0, 16'd0, 8'hF6);
        check_val("brneg", 32'(bus.pc), 32'd15);
        do_op("load", 0, 1, 0, 0, 0, 0, 16'hFFFE, 8'd0);
        do_op("wrap1", 1, 0, 0, 0, 0, 0, 16'd0, 8'd0);
        do_op("wrap2", 1, 0, 0, 0, 0, 0, 16'd0, 8'd0);
        check_val("wrap0", 32'(bus.pc), 32'd0);

        do_op("load", 0, 1, 0, 0, 0, 0, 16'd100, 8'd0);
        for (int i = 0; i < 4; i++)
            do_op("call", 0, 0, 0, 1, 0, 0, 16'(200 + 100 * i), 8'd0);
        check_val("top401", 32'(bus.top), 32'd401);
        check_val("full4", 32'(bus.stack_full), 32'd1);
        do_op("callfull", 0, 0, 0, 1, 0, 0, 16'd600, 8'd0);
        check_val("ovf_pc", 32'(bus.pc), 32'd500);
        check_val("ovf_err", 32'(bus.err), 32'd1);
        for (int i = 0; i < 4; i++) do_op("ret", 0, 0, 0, 0, 1, 0, 16'd0, 8'd0);
        check_val("ret101", 32'(bus.pc), 32'd101);
        do_op("retempty", 0, 0, 0, 0, 1, 0, 16'd0, 8'd0);
        check_val("unf_pc", 32'(bus.pc), 32'd101);
        do_op("errclr", 0, 0, 0, 0, 0, 1, 16'd0, 8'd0);
        check_val("errclr", 32'(bus.err), 32'd0);
        do_op("clrfault", 0, 0, 0, 0, 1, 1, 16'd0, 8'd0);
        check_val("clrfault", 32'(bus.err), 32'd1);

        // Asynchronous reset landing 5 ns before a call's edge.
        do_op("precall", 0, 0, 0, 1, 0, 0, 16'd50, 8'd0);
        @(negedge clk);
        bus.call = 1'b1; bus.target = 16'd35;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("asyncrst");
        @(posedge clk);
        #1;
        check_all("rsthold");
        @(negedge clk);
        rst = 1'b1;
        bus.call = 1'b0;
        do_op("postrst", 0, 0, 0, 0, 0, 0, 16'd0, 8'd0);

        for (int i = 0; i < 400; i++) begin
            do_op("rand", ($urandom_range(3) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(7) == 0),
                  16'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
